jpeg_fifo_ctrl: RTL and testbench

Controller that owns the shared 8-deep x 32-bit JPEG word FIFO. It arbitrates up to NUM_SRC producers (entropy-coder lanes) onto the single FIFO write port with round-robin fairness. It drains the FIFO into a valid/ready output stream through a 2-entry skid buffer, tracks occupancy itself because the FIFO exports no full/empty flags, and sequences FIFO reset and flush.

---
 rtl/jpeg_fifo_pkg.sv | 24 ++
 rtl/jpeg_skid_buf.sv | 60 ++++++
 rtl/jpeg_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_jpeg_fifo_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_fifo_pkg.sv
// rtl/jpeg_fifo_pkg.sv - shared constants and round-robin pick for the JPEG word FIFO controller
package jpeg_fifo_pkg;

  localparam int JPEG_WORD_W    = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int MAX_SRC        = 8;

  // One-hot grant to the first valid lane at or after ptr, wrapping modulo n.
  function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] valid,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_SRC-1:0] g;
    int                 idx;
    g = '0;
    for (int k = 0; k < MAX_SRC; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && (g == '0) && valid[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/jpeg_skid_buf.sv
// rtl/jpeg_skid_buf.sv - two-entry valid/ready buffer holding words read back from the FIFO
module jpeg_skid_buf
  import jpeg_fifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [JPEG_WORD_W-1:0] push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [JPEG_WORD_W-1:0] data_o,
  output logic [1:0]             cnt_o
);

  logic [1:0][JPEG_WORD_W-1:0] mem_q, mem_d;
  logic                        wr_q, wr_d;
  logic                        rd_q, rd_d;
  logic [1:0]                  cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = ~wr_q;
      end
      if (pop_i) begin
        rd_d = ~rd_q;
      end
      cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/jpeg_fifo_ctrl.sv
// rtl/jpeg_fifo_ctrl.sv - round-robin write arbiter, occupancy tracker and read drain for the JPEG word FIFO
module jpeg_fifo_ctrl
  import jpeg_fifo_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             img_rst_n,
  input  logic                             flush,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC*JPEG_WORD_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]               src_ready,
  output logic                             fifo_rst,
  output logic                             fifo_write_req,
  output logic [JPEG_WORD_W-1:0]           fifo_jpeg_in,
  output logic                             fifo_read_req,
  input  logic                             fifo_read_ok,
  input  logic [JPEG_WORD_W-1:0]           fifo_jpeg_out,
  output logic                             out_valid,
  output logic [JPEG_WORD_W-1:0]           out_data,
  input  logic                             out_ready,
  output logic [LVL_W-1:0]                 fifo_level
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  logic                           fifo_rst_q, fifo_rst_d;
  logic [LVL_W-1:0]               count_q, count_d;
  logic [2:0]                     rr_ptr_q, rr_ptr_d;
  logic                           inflight_q, inflight_d;

  logic [MAX_SRC-1:0]             valid_ext, grant;
  logic [MAX_SRC*JPEG_WORD_W-1:0] data_ext;
  logic [2:0]                     winner;
  logic                           blocked, wr, rd, pop, push;
  logic [1:0]                     buf_cnt;

  always_comb begin
    valid_ext                  = '0;
    valid_ext[NUM_SRC-1:0]     = src_valid;
    data_ext                   = '0;
    data_ext[NUM_SRC*32-1:0]   = src_data;
    blocked                    = fifo_rst_q | flush;

    // The FIFO's full check ignores a same-cycle read, so only the committed count gates grants.
    grant = '0;
    if (!blocked && (count_q < DEPTH_L)) begin
      grant = rr_pick(valid_ext, rr_ptr_q, NUM_SRC);
    end
    wr = |grant;

    winner = 3'd0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (grant[i]) winner = 3'(i);
    end

    pop = out_valid & out_ready;
    // buf_cnt + inflight - pop < 2, rearranged to stay unsigned
    rd  = !blocked && (count_q != '0) &&
          (({1'b0, buf_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

    // A read_ok with nothing outstanding, or one landing during a flush, is dropped.
    push = fifo_read_ok & inflight_q & ~flush;

    fifo_rst_d = flush;
    inflight_d = rd;
    count_d    = flush ? '0 : (count_q + LVL_W'(wr) - LVL_W'(rd));
    rr_ptr_d   = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = 3'd0;
    end else if (wr) begin
      rr_ptr_d = (winner == 3'(NUM_SRC - 1)) ? 3'd0 : winner + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge img_rst_n) begin
    if (!img_rst_n) begin
      fifo_rst_q <= 1'b1;
      count_q    <= '0;
      rr_ptr_q   <= 3'd0;
      inflight_q <= 1'b0;
    end else begin
      fifo_rst_q <= fifo_rst_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  jpeg_skid_buf u_skid (
    .clk         (clk),
    .rst_n       (img_rst_n),
    .clr_i       (flush),
    .push_i      (push),
    .push_data_i (fifo_jpeg_out),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .cnt_o       (buf_cnt)
  );

  assign src_ready      = grant[NUM_SRC-1:0];
  assign fifo_write_req = wr;
  assign fifo_jpeg_in   = data_ext[{winner, 5'd0} +: JPEG_WORD_W];
  assign fifo_read_req  = rd;
  assign fifo_rst       = fifo_rst_q;
  assign fifo_level     = count_q;

endmodule

// File: tb/tb_jpeg_fifo_ctrl.sv
// tb/tb_jpeg_fifo_ctrl.sv - jpeg_fifo_ctrl with a behavioural 8x32 FIFO, scoreboard and arbitration model
module tb_jpeg_fifo_ctrl;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            img_rst_n;
  logic            flush;
  logic [N-1:0]    src_valid;
  logic [N*32-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            fifo_rst;
  logic            fifo_write_req;
  logic [31:0]     fifo_jpeg_in;
  logic            fifo_read_req;
  logic            f_ok = 1'b0;
  logic [31:0]     f_dout = '0;
  logic            out_valid;
  logic [31:0]     out_data;
  logic            out_ready;
  logic [LW-1:0]   fifo_level;

  always #5 clk = ~clk;

  jpeg_fifo_ctrl #(.NUM_SRC(N), .FIFO_DEPTH(D), .LVL_W(LW)) dut (
    .clk            (clk),
    .img_rst_n      (img_rst_n),
    .flush          (flush),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .fifo_rst       (fifo_rst),
    .fifo_write_req (fifo_write_req),
    .fifo_jpeg_in   (fifo_jpeg_in),
    .fifo_read_req  (fifo_read_req),
    .fifo_read_ok   (f_ok),
    .fifo_jpeg_out  (f_dout),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .fifo_level     (fifo_level)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] fq[$];
  logic [31:0] sb[$];
  logic        mrst;
  int          mptr = 0;
  int          n_in = 0;
  int          n_out = 0;
  logic [N-1:0] eg;
  int          w;
  bit          full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO: write/read strobes, read data one cycle later, synchronous reset.
  always @(posedge clk) begin
    if (fifo_rst) begin
      fq.delete();
      f_ok <= 1'b0;
    end else begin
      full = (fq.size() >= D);
      f_ok <= fifo_read_req;
      if (fifo_read_req && fq.size() > 0) f_dout <= fq.pop_front();
      if (fifo_write_req && !full) fq.push_back(fifo_jpeg_in);
    end
  end

  always @(posedge clk or negedge img_rst_n) begin
    if (!img_rst_n) mrst <= 1'b1;
    else            mrst <= flush;
  end

  always @(negedge clk) begin
    if (img_rst_n) begin
      eg = '0;
      w  = -1;
      if (!mrst && !flush && fq.size() < D) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && src_valid[(mptr + k) % N]) w = (mptr + k) % N;
        end
      end
      if (w >= 0) eg[w] = 1'b1;
      chk("grant", 32'(src_ready), 32'(eg));
      chk("fifo_rst", 32'(fifo_rst), 32'(mrst));
      if (!mrst) chk("level", 32'(fifo_level), fq.size());
      chk("read_legal", 32'(fifo_read_req && (fq.size() == 0 || mrst || flush)), 32'd0);
      if (w >= 0) begin
        chk("wdata", fifo_jpeg_in, src_data[32*w +: 32]);
        sb.push_back(src_data[32*w +: 32]);
        n_in++;
        mptr = (w + 1) % N;
      end
      if (out_valid && out_ready) begin
        n_out++;
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) chk("out_data", out_data, sb.pop_front());
      end
      if (flush) begin
        sb.delete();
        mptr = 0;
      end
    end else begin
      sb.delete();
      mptr = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int seq[N];
  int in0, out0;

  initial begin
    img_rst_n = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b0;
    tick();
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_wreq", 32'(fifo_write_req), 32'd0);
    chk("rst_rreq", 32'(fifo_read_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_fifo_rst", 32'(fifo_rst), 32'd1);
    tick();
    img_rst_n = 1'b1;
    @(negedge clk);
    chk("rel_hold", 32'(fifo_rst), 32'd1);
    @(negedge clk);
    chk("rel_fifo_rst", 32'(fifo_rst), 32'd0);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_level", 32'(fifo_level), 32'd0);

    // All lanes valid, out_ready high: strict 0,1,2,3 rotation with a grant every cycle.
    tick();
    in0 = n_in; out0 = n_out;
    out_ready = 1'b1;
    src_valid = '1;
    for (int l = 0; l < N; l++) begin
      seq[l] = 0;
      src_data[32*l +: 32] = {8'(l), 24'd0};
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("rr_seq", 32'(src_ready), 32'(1 << (i % N)));
      tick();
      seq[i % N]++;
      src_data[32*(i % N) +: 32] = {8'(i % N), 24'(seq[i % N])};
    end
    src_valid = '0;
    repeat (8) tick();
    chk("rr_in", n_in - in0, 64);
    chk("rr_out", n_out - out0, 64);
    chk("rr_sb_empty", sb.size(), 0);

    // Single word on lane 0: level 1 at t+1, output at t+3.
    src_valid = 4'b0001;
    src_data[31:0] = 32'h1111_1111;
    @(negedge clk);
    chk("one_grant", 32'(src_ready), 32'd1);
    tick();
    src_valid = '0;
    @(negedge clk);
    chk("one_lvl_t1", 32'(fifo_level), 32'd1);
    chk("one_ov_t1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("one_lvl_t2", 32'(fifo_level), 32'd0);
    chk("one_ov_t2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("one_ov_t3", 32'(out_valid), 32'd1);
    chk("one_od_t3", out_data, 32'h1111_1111);
    @(negedge clk);
    chk("one_ov_t4", 32'(out_valid), 32'd0);

    // Backpressure: 8 in the FIFO plus 2 buffered, then everything stalls.
    tick();
    in0 = n_in; out0 = n_out;
    out_ready = 1'b0;
    src_valid = '1;
    for (int i = 0; i < 30; i++) begin
      for (int l = 0; l < N; l++) src_data[32*l +: 32] = $urandom;
      tick();
    end
    @(negedge clk);
    chk("bp_level", 32'(fifo_level), 32'd8);
    chk("bp_ready", 32'(src_ready), 32'd0);
    chk("bp_accepted", n_in - in0, 10);
    chk("bp_rreq", 32'(fifo_read_req), 32'd0);
    tick();
    src_valid = '0;
    out_ready = 1'b1;
    repeat (16) tick();
    chk("bp_drained", n_out - out0, 10);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_level0", 32'(fifo_level), 32'd0);

    // Flush with level 5 and a read outstanding.
    out_ready = 1'b0;
    src_valid = '1;
    for (int i = 0; i < 20; i++) begin
      for (int l = 0; l < N; l++) src_data[32*l +: 32] = $urandom;
      tick();
    end
    src_valid = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_level_t", 32'(fifo_level), 32'd5);
    chk("fl_ov_t", 32'(out_valid), 32'd1);
    chk("fl_rreq_t", 32'(fifo_read_req), 32'd0);
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_level_t1", 32'(fifo_level), 32'd0);
    chk("fl_ov_t1", 32'(out_valid), 32'd0);
    chk("fl_rst_t1", 32'(fifo_rst), 32'd1);
    tick();
    src_valid = 4'b0100;
    src_data[64 +: 32] = 32'hABCD_0123;
    @(negedge clk);
    chk("fl_rst_t2", 32'(fifo_rst), 32'd0);
    chk("fl_grant_t2", 32'(src_ready), 32'b0100);
    tick();
    src_valid = '0;
    @(negedge clk);
    chk("fl_ov_t3", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("fl_ov_t4", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("fl_ov_t5", 32'(out_valid), 32'd1);
    chk("fl_od_t5", out_data, 32'hABCD_0123);

    // Random traffic, backpressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      tick();
      src_valid = N'($urandom);
      for (int l = 0; l < N; l++) src_data[32*l +: 32] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
    end
    tick();
    src_valid = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    chk("rnd_sb_empty", sb.size(), 0);
    chk("rnd_ov", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stalled stream.
    out_ready = 1'b0;
    src_valid = '1;
    repeat (15) tick();
    @(negedge clk);
    chk("ar_ov_before", 32'(out_valid), 32'd1);
    chk("ar_lvl_before", 32'(fifo_level), 32'd8);
    #2;
    img_rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_od", out_data, 32'd0);
    chk("ar_level", 32'(fifo_level), 32'd0);
    chk("ar_ready", 32'(src_ready), 32'd0);
    chk("ar_wreq", 32'(fifo_write_req), 32'd0);
    chk("ar_fifo_rst", 32'(fifo_rst), 32'd1);
    repeat (2) tick();
    img_rst_n = 1'b1;
    @(negedge clk);
    chk("ar_hold_ready", 32'(src_ready), 32'd0);
    @(negedge clk);
    chk("ar_first_lane0", 32'(src_ready), 32'd1);
    tick();
    src_valid = '0;
    out_ready = 1'b1;
    repeat (12) tick();
    chk("ar_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
